// File: rtl/ft600_emu_pkg.sv
// Shared types and constants for the FT600 245-synchronous-FIFO device emulator.
package ft600_emu_pkg;

  localparam int FT600_DATA_W = 16;
  localparam int FT600_BE_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2,
    ST_GAP  = 2'd3
  } emu_state_e;

  typedef struct packed {
    logic [FT600_BE_W-1:0]   be;
    logic [FT600_DATA_W-1:0] data;
  } ft600_word_t;

endpackage

// File: rtl/ft600_bus_emulator_if.sv
// FT600 parallel bus with the tri-state data/be split into master-driven (_i)
// and emulator-driven (_o/_oe) halves; a board wrapper forms the inout.
interface ft600_bus_emulator_if #(
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);
  logic              ftdi_rxf_n;
  logic              ftdi_txe_n;
  logic              ftdi_oe_n;
  logic              ftdi_rd_n;
  logic              ftdi_wr_n;
  logic [DATA_W-1:0] ftdi_data_i;
  logic [BE_W-1:0]   ftdi_be_i;
  logic [DATA_W-1:0] ftdi_data_o;
  logic [BE_W-1:0]   ftdi_be_o;
  logic              ftdi_data_oe;

  modport master (
    input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_data_oe,
    output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i
  );

  modport slave (
    output ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_data_oe,
    input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i
  );
endinterface

// File: rtl/ft600_emu_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Pushes while full and pops while empty are ignored.
module ft600_emu_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wdata,
  output logic                       full,
  input  logic                       rd_en,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = mem[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (pop && !push) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ft600_bus_emulator.sv
// Device-side FT600 bus model: arbitrates RX (to master) and TX (from master)
// sessions, frames each with registered flags and separates them by a gap.
module ft600_bus_emulator
  import ft600_emu_pkg::*;
#(
  parameter int DATA_W     = FT600_DATA_W,
  parameter int BE_W       = FT600_BE_W,
  parameter int RX_DEPTH   = 64,
  parameter int TX_DEPTH   = 64,
  parameter int MAX_BURST  = 32,
  parameter int TURN_GAP   = 2,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  ft600_bus_emulator_if.slave          bus,
  input  logic [BE_W+DATA_W-1:0]       host_rx_wdata,
  input  logic                         host_rx_wvalid,
  output logic                         host_rx_wready,
  output logic [BE_W+DATA_W-1:0]       host_tx_rdata,
  output logic                         host_tx_rvalid,
  input  logic                         host_tx_rready,
  output logic [$clog2(RX_DEPTH):0]    rx_level,
  output logic [$clog2(TX_DEPTH):0]    tx_level,
  output logic                         protocol_error,
  output emu_state_e                   dbg_state
);
  localparam int WW      = BE_W + DATA_W;
  localparam int RXL_W   = $clog2(RX_DEPTH) + 1;
  localparam int TXL_W   = $clog2(TX_DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W   = $clog2(TURN_GAP + 1);
  localparam int TMO_W   = $clog2(TX_TIMEOUT + 1);

  emu_state_e         state_q, state_d;
  logic               prefer_rx_q, prefer_rx_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wrote_q, wrote_d;
  logic               rxf_n_q, rxf_n_d;
  logic               txe_n_q, txe_n_d;
  logic               data_oe_q, data_oe_d;
  logic               err_q, err_d;
  logic               end_session;

  logic [WW-1:0] rx_head;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic          rx_drained, tx_filled, burst_hit;

  // Host ports use valid/ready: a word moves on a clock edge where both are
  // high; valid while not ready is simply not a transfer (no stall or error).
  ft600_emu_fifo #(.W(WW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (host_rx_wvalid),
    .wdata (host_rx_wdata),
    .full  (rx_full),
    .rd_en (rx_pop),
    .rdata (rx_head),
    .empty (rx_empty),
    .level (rx_level)
  );

  ft600_emu_fifo #(.W(WW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (tx_push),
    .wdata ({bus.ftdi_be_i, bus.ftdi_data_i}),
    .full  (tx_full),
    .rd_en (host_tx_rready),
    .rdata (host_tx_rdata),
    .empty (tx_empty),
    .level (tx_level)
  );

  always_comb begin
    rx_push    = host_rx_wvalid && !rx_full;
    rx_pop     = (state_q == ST_RX) && !bus.ftdi_oe_n && !bus.ftdi_rd_n && !rx_empty;
    tx_push    = (state_q == ST_TX) && !bus.ftdi_wr_n && !tx_full;
    tx_pop     = host_tx_rready && !tx_empty;
    // Look-ahead on the post-edge occupancy so host traffic in the same
    // cycle can keep a session alive.
    rx_drained = rx_pop && !rx_push && (rx_level == RXL_W'(1));
    tx_filled  = tx_push && !tx_pop && (tx_level == TXL_W'(TX_DEPTH - 1));
    burst_hit  = (burst_q == BURST_W'(MAX_BURST - 1));
  end

  always_comb begin
    state_d     = state_q;
    prefer_rx_d = prefer_rx_q;
    burst_d     = burst_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    wrote_d     = wrote_q;
    end_session = 1'b0;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        gap_d   = '0;
        tmo_d   = '0;
        wrote_d = 1'b0;
        if (!rx_empty && (prefer_rx_q || tx_full))       state_d = ST_RX;
        else if (!tx_full && (!prefer_rx_q || rx_empty)) state_d = ST_TX;
      end
      ST_RX: begin
        if (rx_pop) begin
          burst_d = burst_q + BURST_W'(1);
          if (rx_drained || burst_hit) end_session = 1'b1;
        end
      end
      ST_TX: begin
        if (tx_push) begin
          burst_d = burst_q + BURST_W'(1);
          wrote_d = 1'b1;
          if (tx_filled || burst_hit) end_session = 1'b1;
        end else if (wrote_q) begin
          if (bus.ftdi_wr_n) end_session = 1'b1;
        end else if (tmo_q == TMO_W'(TX_TIMEOUT - 1)) begin
          end_session = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(TURN_GAP - 1)) state_d = ST_IDLE;
        else                               gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (end_session) begin
      state_d     = ST_GAP;
      prefer_rx_d = !prefer_rx_q;
      gap_d       = '0;
    end
  end

  // Flags follow the next state so they are valid exactly while the session is.
  always_comb begin
    rxf_n_d   = (state_d != ST_RX);
    txe_n_d   = (state_d != ST_TX);
    data_oe_d = !bus.ftdi_oe_n;
    err_d     = err_q
              | (!bus.ftdi_rd_n && bus.ftdi_oe_n)
              | (!bus.ftdi_rd_n && rxf_n_q)
              | (!bus.ftdi_wr_n && txe_n_q)
              | (!bus.ftdi_oe_n && (state_q == ST_TX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prefer_rx_q <= 1'b1;
      burst_q     <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      wrote_q     <= 1'b0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      data_oe_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prefer_rx_q <= prefer_rx_d;
      burst_q     <= burst_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      wrote_q     <= wrote_d;
      rxf_n_q     <= rxf_n_d;
      txe_n_q     <= txe_n_d;
      data_oe_q   <= data_oe_d;
      err_q       <= err_d;
    end
  end

  assign bus.ftdi_rxf_n   = rxf_n_q;
  assign bus.ftdi_txe_n   = txe_n_q;
  assign bus.ftdi_data_oe = data_oe_q;
  assign bus.ftdi_data_o  = rx_head[DATA_W-1:0];
  assign bus.ftdi_be_o    = rx_head[WW-1:DATA_W];
  assign host_rx_wready   = !rx_full;
  assign host_tx_rvalid   = !tx_empty;
  assign protocol_error   = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ft600_bus_emulator.sv
// Bench for ft600_bus_emulator: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based model of the bus rules.
module tb_ft600_bus_emulator;
  import ft600_emu_pkg::*;

  localparam int DW = 16, BW = 2, WW = 18;
  localparam int RX_DEPTH = 64, TX_DEPTH = 64, MAX_BURST = 32;
  localparam int TURN_GAP = 2, TX_TIMEOUT = 16;
  localparam int M_IDLE = 0, M_RX = 1, M_TX = 2, M_GAP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft600_bus_emulator_if #(.DATA_W(DW), .BE_W(BW)) bus ();

  logic [WW-1:0] host_rx_wdata;
  logic          host_rx_wvalid, host_rx_wready;
  logic [WW-1:0] host_tx_rdata;
  logic          host_tx_rvalid, host_tx_rready;
  logic [6:0]    rx_level, tx_level;
  logic          protocol_error;
  emu_state_e    dbg_state;

  ft600_bus_emulator #(
    .DATA_W(DW), .BE_W(BW), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH),
    .MAX_BURST(MAX_BURST), .TURN_GAP(TURN_GAP), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .host_rx_wdata(host_rx_wdata), .host_rx_wvalid(host_rx_wvalid),
    .host_rx_wready(host_rx_wready),
    .host_tx_rdata(host_tx_rdata), .host_tx_rvalid(host_tx_rvalid),
    .host_tx_rready(host_tx_rready),
    .rx_level(rx_level), .tx_level(tx_level),
    .protocol_error(protocol_error), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WW-1:0] rx_exp_q[$];
  logic [WW-1:0] tx_exp_q[$];
  int  m_state, m_burst, m_gap, m_idle;
  bit  m_prefer, m_wrote, m_rxf_n, m_txe_n, m_oe, m_err, mv;

  initial mv = 1'b0;

  always @(posedge clk) begin
    int rxn, txn;
    bit rpush, rpop, tpush, tpop, fin, oe, rd, wr;
    if (rst) begin
      rx_exp_q.delete(); tx_exp_q.delete();
      m_state = M_IDLE; m_prefer = 1; m_rxf_n = 1; m_txe_n = 1; m_oe = 0; m_err = 0;
      m_burst = 0; m_gap = 0; m_idle = 0; m_wrote = 0; mv = 1;
    end else if (mv) begin
      oe = bus.ftdi_oe_n; rd = bus.ftdi_rd_n; wr = bus.ftdi_wr_n;
      rxn = rx_exp_q.size(); txn = tx_exp_q.size();
      rpush = host_rx_wvalid && (rxn < RX_DEPTH);
      rpop  = (m_state == M_RX) && !oe && !rd && (rxn > 0);
      tpush = (m_state == M_TX) && !wr && (txn < TX_DEPTH);
      tpop  = host_tx_rready && (txn > 0);
      if ((!rd && oe) || (!rd && m_rxf_n) || (!wr && m_txe_n) || (!oe && m_state == M_TX)) m_err = 1;
      if (rpop)  void'(rx_exp_q.pop_front());
      if (rpush) rx_exp_q.push_back(host_rx_wdata);
      if (tpop)  void'(tx_exp_q.pop_front());
      if (tpush) tx_exp_q.push_back({bus.ftdi_be_i, bus.ftdi_data_i});
      fin = 0;
      case (m_state)
        M_IDLE: begin
          m_burst = 0; m_idle = 0; m_wrote = 0;
          if (rxn > 0 && (m_prefer || txn == TX_DEPTH)) m_state = M_RX;
          else if (txn < TX_DEPTH && (!m_prefer || rxn == 0)) m_state = M_TX;
        end
        M_RX: if (rpop) begin
          m_burst++;
          if (rx_exp_q.size() == 0 || m_burst == MAX_BURST) fin = 1;
        end
        M_TX: begin
          if (tpush) begin
            m_burst++; m_wrote = 1;
            if (tx_exp_q.size() == TX_DEPTH || m_burst == MAX_BURST) fin = 1;
          end else if (m_wrote) fin = wr;
          else begin
            m_idle++;
            if (m_idle == TX_TIMEOUT) fin = 1;
          end
        end
        default: begin
          m_gap++;
          if (m_gap == TURN_GAP) m_state = M_IDLE;
        end
      endcase
      if (fin) begin m_state = M_GAP; m_gap = 0; m_prefer = !m_prefer; end
      m_rxf_n = (m_state != M_RX);
      m_txe_n = (m_state != M_TX);
      m_oe    = !oe;
    end
  end

  function automatic emu_state_e exp_state(input int s);
    case (s)
      M_RX:    return ST_RX;
      M_TX:    return ST_TX;
      M_GAP:   return ST_GAP;
      default: return ST_IDLE;
    endcase
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (mv) begin
      check("rxf_n", 32'(bus.ftdi_rxf_n), 32'(m_rxf_n));
      check("txe_n", 32'(bus.ftdi_txe_n), 32'(m_txe_n));
      check("data_oe", 32'(bus.ftdi_data_oe), 32'(m_oe));
      check("protocol_error", 32'(protocol_error), 32'(m_err));
      check("rx_level", 32'(rx_level), 32'(rx_exp_q.size()));
      check("tx_level", 32'(tx_level), 32'(tx_exp_q.size()));
      check("rx_wready", 32'(host_rx_wready), 32'(rx_exp_q.size() < RX_DEPTH));
      check("tx_rvalid", 32'(host_tx_rvalid), 32'(tx_exp_q.size() > 0));
      check("state", 32'(dbg_state), 32'(exp_state(m_state)));
      if (rx_exp_q.size() > 0)
        check("rx_head", 32'({bus.ftdi_be_o, bus.ftdi_data_o}), 32'(rx_exp_q[0]));
      if (tx_exp_q.size() > 0)
        check("tx_head", 32'(host_tx_rdata), 32'(tx_exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  bit rd_allow, wr_allow;
  int rd_skip, wr_skip, illegal_pct;

  task automatic master_drive();
    logic oe, rd, wr;
    oe = 1; rd = 1; wr = 1;
    if (rd_allow && bus.ftdi_rxf_n == 1'b0) begin
      oe = 0;
      rd = ($urandom_range(0, 99) < rd_skip);
    end else if (wr_allow && bus.ftdi_txe_n == 1'b0) begin
      wr = ($urandom_range(0, 99) < wr_skip);
    end
    if ($urandom_range(0, 99) < illegal_pct) begin
      oe = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
    end
    bus.ftdi_oe_n   = oe;
    bus.ftdi_rd_n   = rd;
    bus.ftdi_wr_n   = wr;
    bus.ftdi_data_i = 16'($urandom);
    bus.ftdi_be_i   = 2'($urandom);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      master_drive();
      @(negedge clk);
    end
  endtask

  task automatic wait_flag_low(input string name, input bit use_txe, input int limit);
    int cnt = 0;
    while ((use_txe ? bus.ftdi_txe_n : bus.ftdi_rxf_n) !== 1'b0 && cnt < limit) begin
      master_drive();
      @(negedge clk);
      cnt++;
    end
    if (cnt >= limit) begin
      n_vec++; n_err++;
      $display("FAIL %s: flag still high after %0d cycles, required low", name, limit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.ftdi_oe_n = 1; bus.ftdi_rd_n = 1; bus.ftdi_wr_n = 1;
    bus.ftdi_data_i = '0; bus.ftdi_be_i = '0;
    host_rx_wdata = '0; host_rx_wvalid = 0; host_tx_rready = 0;
    rd_allow = 0; wr_allow = 0; rd_skip = 0; wr_skip = 0; illegal_pct = 0;

    repeat (3) @(negedge clk);
    check("reset rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);
    check("reset txe_n", 32'(bus.ftdi_txe_n), 32'd1);
    check("reset data_oe", 32'(bus.ftdi_data_oe), 32'd0);
    check("reset rx_level", 32'(rx_level), 32'd0);
    check("reset tx_level", 32'(tx_level), 32'd0);
    check("reset protocol_error", 32'(protocol_error), 32'd0);
    rst = 0;

    // Host loads 8 words; master only reads.
    rd_allow = 1;
    for (int i = 0; i < 8; i++) begin
      host_rx_wvalid = 1;
      host_rx_wdata  = {2'b11, 16'h3130 + 16'(i) * 16'h0202};
      master_drive();
      @(negedge clk);
    end
    host_rx_wvalid = 0;
    check("p1 rx_level", 32'(rx_level), 32'd8);
    check("p1 head", 32'({bus.ftdi_be_o, bus.ftdi_data_o}), 32'h33130);
    run_cycles(80);
    check("p1 drained", 32'(rx_level), 32'd0);
    check("p1 rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);

    // Master writes 4 words then releases wr_n; host drains them.
    rd_allow = 0;
    wait_flag_low("p2 txe wait", 1'b1, 100);
    for (int i = 0; i < 4; i++) begin
      bus.ftdi_wr_n = 0; bus.ftdi_oe_n = 1; bus.ftdi_rd_n = 1;
      bus.ftdi_data_i = 16'hA001 + 16'(i);
      bus.ftdi_be_i   = 2'b01;
      @(negedge clk);
    end
    bus.ftdi_wr_n = 1;
    repeat (3) @(negedge clk);
    check("p2 tx_level", 32'(tx_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("p2 tx word", 32'(host_tx_rdata), 32'({2'b01, 16'hA001 + 16'(i)}));
      host_tx_rready = 1;
      @(negedge clk);
      host_tx_rready = 0;
    end
    check("p2 tx empty", 32'(tx_level), 32'd0);

    // 40 words toward the master, bursts capped at MAX_BURST.
    rd_allow = 1;
    for (int i = 0; i < 40; i++) begin
      host_rx_wvalid = 1;
      host_rx_wdata  = 18'($urandom);
      master_drive();
      @(negedge clk);
    end
    host_rx_wvalid = 0;
    run_cycles(200);
    check("p3 drained", 32'(rx_level), 32'd0);

    // Fill TX completely, then a strobe while txe_n is high.
    rd_allow = 0; wr_allow = 1; wr_skip = 0;
    run_cycles(300);
    check("p4 tx full", 32'(tx_level), 32'd64);
    check("p4 txe_n", 32'(bus.ftdi_txe_n), 32'd1);
    bus.ftdi_wr_n = 0; bus.ftdi_oe_n = 1; bus.ftdi_rd_n = 1;
    @(negedge clk);
    bus.ftdi_wr_n = 1;
    check("p4 protocol_error", 32'(protocol_error), 32'd1);
    check("p4 strobe ignored", 32'(tx_level), 32'd64);

    // Reset in the middle of an RX burst.
    rst = 1; @(negedge clk); rst = 0;
    wr_allow = 0; rd_allow = 1; rd_skip = 0;
    for (int i = 0; i < 20; i++) begin
      host_rx_wvalid = 1;
      host_rx_wdata  = 18'($urandom);
      master_drive();
      @(negedge clk);
    end
    host_rx_wvalid = 0;
    wait_flag_low("p5 rxf wait", 1'b0, 200);
    run_cycles(3);
    rst = 1;
    master_drive();
    @(negedge clk);
    check("p5 rst rxf_n", 32'(bus.ftdi_rxf_n), 32'd1);
    check("p5 rst data_oe", 32'(bus.ftdi_data_oe), 32'd0);
    check("p5 rst rx_level", 32'(rx_level), 32'd0);
    check("p5 rst tx_level", 32'(tx_level), 32'd0);
    check("p5 rst protocol_error", 32'(protocol_error), 32'd0);
    rst = 0;

    // Random traffic with occasional illegal strobes and resets.
    rd_allow = 1; wr_allow = 1; rd_skip = 25; wr_skip = 15; illegal_pct = 2;
    repeat (3000) begin
      rst            = ($urandom_range(0, 299) == 0);
      host_rx_wvalid = ($urandom_range(0, 99) < 50);
      host_rx_wdata  = 18'($urandom);
      host_tx_rready = ($urandom_range(0, 99) < 40);
      master_drive();
      @(negedge clk);
    end
    rst = 0; host_rx_wvalid = 0; host_tx_rready = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
